load_store_unit: RTL

Bridges the single-cycle datapath's data-memory port to a slower handshaked memory bus. It sits directly downstream of the datapath, taking the ALU address, rs2 store data, MemRead/MemWrite and funct3. It stalls the datapath while a transaction is in flight. It handles byte/halfword/word access with byte enables, sign/zero extension, misalignment detection and a bus timeout.

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the single-cycle datapath's data-memory port to a handshaked
//   memory bus. Aligned accesses stall the datapath while the bus transaction
//   is in flight. Misaligned accesses are rejected in a single cycle without
//   touching the bus. The unit also enforces a bus timeout.
//
// Ports
//   clock, reset_n           clock, async active-low reset
//   iRead/iWrite             load/store request (store wins if both are high)
//   iFunct3                  000 B, 001 H, 010 W, 100 BU, 101 HU, others as W
//   iAddress/iData           byte address, store data (rs2)
//   oData                    formatted load data, non-zero only in DONE
//   oStall                   datapath hold
//   oMisaligned              one-cycle reject flag
//   oTimeout                 one-cycle flag in DONE of an aborted access
//   oBusReq/oBusWe/oBusAddr/oBusWData/oBusByteEn   bus request side
//   iBusAck/iBusRData        bus completion and read word
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oStall,
  output logic        oMisaligned,
  output logic        oTimeout,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  output logic [3:0]  oBusByteEn,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [29:0] r_addr;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_tmo;

  logic        w_req, w_is_b, w_is_h, w_mis, w_start, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request decode. The access size comes from funct3[1:0]: 00 is byte,
  // 01 is half, and anything else is word.
  assign w_req   = iRead | iWrite;
  assign w_is_b  = (iFunct3[1:0] == 2'b00);
  assign w_is_h  = (iFunct3[1:0] == 2'b01);
  assign w_mis   = (w_is_h & iAddress[0]) | (~w_is_b & ~w_is_h & (|iAddress[1:0]));
  assign w_start = (r_state == S_IDLE) & w_req & ~w_mis;
  // Ack on the final allowed cycle still completes normally.
  assign w_tmo   = (r_state == S_BUSY) & ~iBusAck & (r_cnt == TO_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = iData;
    if (w_is_b) begin
      w_be    = 4'b0001 << iAddress[1:0];
      w_wdata = {4{iData[7:0]}};
    end else if (w_is_h) begin
      w_be    = 4'b0011 << {iAddress[1], 1'b0};
      w_wdata = {2{iData[15:0]}};
    end
  end

  // Load formatting uses the latched offset and funct3, not the live inputs.
  assign w_byte = iBusRData[{r_off, 3'b000} +: 8];
  assign w_half = iBusRData[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_f3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = iBusRData;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_BUSY;
      S_BUSY:  if (iBusAck || w_tmo) w_next = S_DONE;
      // DONE never restarts on the request still held by the datapath.
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction context, cycle counter and captured load data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_off   <= '0;
      r_f3    <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_tmo   <= 1'b0;
    end else if (w_start) begin
      r_addr  <= iAddress[31:2];
      r_off   <= iAddress[1:0];
      r_f3    <= iFunct3;
      r_we    <= iWrite;
      r_wdata <= w_wdata;
      r_be    <= w_be;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_tmo   <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 16'd1;
      if (iBusAck)    r_rdata <= r_we ? 32'd0 : w_ldata;
      else if (w_tmo) r_tmo   <= 1'b1;
    end
  end

  // Outputs. Bus outputs are driven only from latched state while BUSY.
  always_comb begin
    oData       = '0;
    oStall      = 1'b0;
    oMisaligned = 1'b0;
    oTimeout    = 1'b0;
    oBusReq     = 1'b0;
    oBusWe      = 1'b0;
    oBusAddr    = '0;
    oBusWData   = '0;
    oBusByteEn  = '0;
    case (r_state)
      S_IDLE: begin
        oStall      = reset_n & w_start;
        oMisaligned = reset_n & w_req & w_mis;
      end
      S_BUSY: begin
        oStall     = 1'b1;
        oBusReq    = 1'b1;
        oBusWe     = r_we;
        oBusAddr   = {r_addr, 2'b00};
        oBusWData  = r_wdata;
        oBusByteEn = r_be;
      end
      S_DONE: begin
        oData    = r_rdata;
        oTimeout = r_tmo;
      end
      default: ;
    endcase
  end

endmodule
